marker_pixel_scanner: RTL and testbench

- Upstream feeder for the marker-coordinate stage.
- Scans the 320x240 RGB444 camera frame buffer (BRAM read port) once per frame.
- Classifies each pixel against green-marker thresholds and emits the downstream stream: vsync, address, and frame_pixel (MARK_COLOR for marker pixels, 12'h000 otherwise).
- Also reports a per-frame marker pixel count and a frame-done pulse.

---
 rtl/marker_pixel_scanner.sv | 144 ++++++++++++++
 tb/tb_marker_pixel_scanner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/marker_pixel_scanner.sv
// Frame-buffer scanner: streams every pixel once per frame, tags green markers,
// and reports the per-frame marker count with a frame-done pulse.
module marker_pixel_scanner #(
    parameter int          H_RES        = 320,
    parameter int          V_RES        = 240,
    parameter int          BRAM_LATENCY = 1,
    parameter int          VSYNC_CYCLES = 4,
    parameter logic [3:0]  G_MIN        = 4'd8,
    parameter logic [3:0]  R_MAX        = 4'd6,
    parameter logic [3:0]  B_MAX        = 4'd6,
    parameter logic [11:0] MARK_COLOR   = 12'h770
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    output logic [16:0] bram_addr,
    input  logic [11:0] bram_dout,
    output logic        vsync,
    output logic [16:0] address,
    output logic [11:0] frame_pixel,
    output logic        pixel_valid,
    output logic [16:0] marker_count,
    output logic        frame_done
);

    localparam int          FRAME_PIXELS = H_RES * V_RES;
    localparam int          LAT          = BRAM_LATENCY;
    localparam logic [16:0] LAST_ADDR    = 17'(FRAME_PIXELS - 1);
    localparam logic [16:0] EOF_ADDR     = 17'(FRAME_PIXELS);
    localparam int          CW = $clog2(VSYNC_CYCLES + BRAM_LATENCY + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SCAN,
        DRAIN,
        EOF
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [16:0]     addr_d;
    logic [LAT-1:0]  req_v;
    logic [16:0]     req_a [LAT];
    logic [16:0]     run_cnt;
    logic [3:0]      px_r, px_g, px_b;
    logic            is_mark;
    logic            hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = SYNC;
            end
            SYNC: begin
                if (cnt_q == CW'(VSYNC_CYCLES - 1)) state_d = SCAN;
                else cnt_d = cnt_q + 1'b1;
            end
            SCAN: begin
                if (bram_addr == LAST_ADDR) begin
                    state_d = DRAIN;
                    addr_d  = LAST_ADDR;
                end else begin
                    addr_d = bram_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(LAT)) begin
                    state_d = EOF;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = bram_addr;
                end
            end
            EOF: begin
                state_d = enable ? SYNC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bram_addr <= '0;
            vsync     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bram_addr <= addr_d;
            vsync     <= (state_d == IDLE) || (state_d == SYNC);
        end
    end

    // Tracks which read address the BRAM is returning this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_v <= '0;
            for (int i = 0; i < LAT; i++) req_a[i] <= '0;
        end else begin
            req_v[0] <= (state_q == SCAN);
            req_a[0] <= bram_addr;
            for (int i = 1; i < LAT; i++) begin
                req_v[i] <= req_v[i-1];
                req_a[i] <= req_a[i-1];
            end
        end
    end

    assign px_r    = bram_dout[11:8];
    assign px_g    = bram_dout[7:4];
    assign px_b    = bram_dout[3:0];
    assign is_mark = (px_g >= G_MIN) && (px_r <= R_MAX) && (px_b <= B_MAX);
    assign hit     = req_v[LAT-1] && is_mark;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            address      <= '0;
            frame_pixel  <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            marker_count <= '0;
            run_cnt      <= '0;
        end else if (state_d == EOF) begin
            address      <= EOF_ADDR;
            frame_pixel  <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b1;
            marker_count <= run_cnt;
            run_cnt      <= '0;
        end else begin
            pixel_valid  <= req_v[LAT-1];
            address      <= req_v[LAT-1] ? req_a[LAT-1] : 17'd0;
            frame_pixel  <= hit ? MARK_COLOR : 12'h000;
            frame_done   <= 1'b0;
            if (hit) run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_marker_pixel_scanner.sv
// Directed bench: two scanner instances (BRAM latency 1 and 2) on a reduced
// 8x6 frame, checked cycle by cycle against hand-derived frame timing.
module tb_marker_pixel_scanner;

    localparam int VS = 4;
    localparam int FP = 48;

    logic        clk;
    logic        resetn;
    logic        enable;

    logic [16:0] ba1, addr1, mc1;
    logic [11:0] dout1, fp1;
    logic        vs1, pv1, fd1;

    logic [16:0] ba2, addr2, mc2;
    logic [11:0] dout2, d2a, fp2;
    logic        vs2, pv2, fd2;

    logic [11:0] mem     [64];
    logic [11:0] exp_pix [64];

    int checks;
    int errors;

    marker_pixel_scanner #(
        .H_RES(8), .V_RES(6), .BRAM_LATENCY(1), .VSYNC_CYCLES(VS)
    ) u_dut1 (
        .clk(clk), .resetn(resetn), .enable(enable),
        .bram_addr(ba1), .bram_dout(dout1), .vsync(vs1),
        .address(addr1), .frame_pixel(fp1), .pixel_valid(pv1),
        .marker_count(mc1), .frame_done(fd1)
    );

    marker_pixel_scanner #(
        .H_RES(8), .V_RES(6), .BRAM_LATENCY(2), .VSYNC_CYCLES(VS)
    ) u_dut2 (
        .clk(clk), .resetn(resetn), .enable(enable),
        .bram_addr(ba2), .bram_dout(dout2), .vsync(vs2),
        .address(addr2), .frame_pixel(fp2), .pixel_valid(pv2),
        .marker_count(mc2), .frame_done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        dout1 <= mem[ba1[5:0]];
        d2a   <= mem[ba2[5:0]];
        dout2 <= d2a;
    end

    function automatic logic [48:0] exp_vec(int lat, int c, int nf,
                                            int pc, int nc);
        int p, f, cc, idx;
        logic pv, fd, vs;
        logic [16:0] ad, mc;
        logic [11:0] px;
        p  = VS + FP + lat + 2;
        f  = (c - 1) / p;
        cc = (c - 1) % p + 1;
        if (f >= nf) return {3'b100, 17'd0, 12'd0, 17'(nc)};
        idx = cc - (VS + lat + 2);
        vs  = (cc <= VS);
        pv  = (idx >= 0) && (idx < FP);
        fd  = (cc == p);
        px  = 12'h000;
        if (pv) px = exp_pix[idx];
        ad  = pv ? 17'(idx) : (fd ? 17'(FP) : 17'd0);
        mc  = (f == 0 && cc < p) ? 17'(pc) : 17'(nc);
        return {vs, pv, fd, ad, px, mc};
    endfunction

    function automatic int exp_ba(int lat, int c, int nf);
        int p, f, cc;
        p  = VS + FP + lat + 2;
        f  = (c - 1) / p;
        cc = (c - 1) % p + 1;
        if (f >= nf)       return 0;
        if (cc <= VS)      return 0;
        if (cc <= VS + FP) return cc - VS - 1;
        if (cc < p)        return FP - 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %h expected %h", tag, c, obs, exp);
        end
    endtask

    task automatic check_all(input int c, input int nf,
                             input int pc, input int nc);
        int e;
        chk("l1_out", c, {vs1, pv1, fd1, addr1, fp1, mc1},
            exp_vec(1, c, nf, pc, nc));
        chk("l2_out", c, {vs2, pv2, fd2, addr2, fp2, mc2},
            exp_vec(2, c, nf, pc, nc));
        e = exp_ba(1, c, nf);
        if (e >= 0) chk("l1_bram_addr", c, 64'(ba1), 64'(e));
        e = exp_ba(2, c, nf);
        if (e >= 0) chk("l2_bram_addr", c, 64'(ba2), 64'(e));
    endtask

    task automatic run(input int ncyc, input int nf, input int drop_c,
                       input int pc, input int nc);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            check_all(c, nf, pc, nc);
            if (c == drop_c) enable = 1'b0;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 12'h000;
            exp_pix[i] = 12'h000;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        enable = 1'b0;
        clear_mem();

        repeat (3) @(negedge clk);
        check_all(1, 0, 0, 0);
        resetn = 1'b1;
        run(5, 0, 0, 0, 0);

        // markers at first, second-line and last pixels, plus threshold edges
        mem[0]  = 12'h3A2; exp_pix[0]  = 12'h770;
        mem[9]  = 12'h0F0; exp_pix[9]  = 12'h770;
        mem[47] = 12'h2C1; exp_pix[47] = 12'h770;
        mem[10] = 12'h686; exp_pix[10] = 12'h770;
        mem[11] = 12'h786;
        mem[12] = 12'h676;
        mem[13] = 12'h687;
        enable = 1'b1;
        run(64, 1, 25, 0, 4);

        clear_mem();
        mem[0]  = 12'h3A2; exp_pix[0]  = 12'h770;
        mem[9]  = 12'h0F0; exp_pix[9]  = 12'h770;
        mem[47] = 12'h2C1; exp_pix[47] = 12'h770;
        enable = 1'b1;
        run(30, 1, 0, 4, 4);
        resetn = 1'b0;
        #1;
        chk("async_rst_l1", 0, {vs1, pv1, fd1, addr1, fp1, mc1},
            exp_vec(1, 1, 0, 0, 0));
        chk("async_rst_l2", 0, {vs2, pv2, fd2, addr2, fp2, mc2},
            exp_vec(2, 1, 0, 0, 0));
        chk("async_rst_ba", 0, {ba1, ba2}, 64'd0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run(4, 0, 0, 0, 0);

        enable = 1'b1;
        run(116, 2, 80, 0, 3);

        clear_mem();
        enable = 1'b1;
        run(60, 1, 10, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
